// File: rtl/mem_param_pkg.sv
// Shared definitions for the parameterised single-port memory controller:
// FSM state encoding, legal read-latency range and the word parity helper.
// Parity storage is only built when MEM_PARAM_PARITY_EN is defined.
package mem_param_pkg;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Widest word the parity helper accepts; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int PAR_MAX_W = 1024;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RSP     = 2'd2
   } state_e;

   // Even parity: the returned bit makes the total count of ones even.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/mem_param_array.sv
// Word storage with byte-enable writes and an asynchronous read port.
// With MEM_PARAM_PARITY_EN defined, one even-parity bit per word is kept
// alongside the data and compared on every read.
// Contents are deliberately not reset.
module mem_param_array
   import mem_param_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
`ifdef MEM_PARAM_PARITY_EN
   input  logic                wr_par_flip,
`endif
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_par_err
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] merged;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              wr_in_range;
   logic              rd_in_range;

   assign wr_in_range = int'(wr_addr) < DEPTH;
   assign rd_in_range = int'(rd_addr) < DEPTH;
   assign wr_idx      = wr_addr[IDX_W-1:0];
   assign rd_idx      = rd_addr[IDX_W-1:0];

   // Merge enabled bytes of the new data over the currently stored word.
   always_comb begin
      merged = mem[wr_idx];
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
      end
   end

   // Out-of-range writes leave the array untouched.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) mem[wr_idx] <= merged;
   end

   assign rd_data = rd_in_range ? mem[rd_idx] : '0;

`ifdef MEM_PARAM_PARITY_EN
   logic par_mem [DEPTH];

   // Parity is recomputed over the merged word; the flip input lets a test
   // plant a corrupted parity bit.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range)
         par_mem[wr_idx] <= even_parity(PAR_MAX_W'(merged)) ^ wr_par_flip;
   end

   assign rd_par_err = rd_in_range &&
                       (par_mem[rd_idx] != even_parity(PAR_MAX_W'(rd_data)));
`else
   assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/mem_param_ctrl.sv
// Request/response controller around mem_param_array. One transaction is
// in flight at a time; the response is held until rsp_ready.
// Optional feature: MEM_PARAM_PARITY_EN adds the par_inject input and
// reports stored-parity mismatches on reads through rsp_err.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | ready for a request (req_ready=1)
//   RD_WAIT | read accepted, extra latency cycle (RD_LAT=2 only)
//   RSP     | response presented, waiting for rsp_ready
module mem_param_ctrl
   import mem_param_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
`ifdef MEM_PARAM_PARITY_EN
   input  logic                par_inject,
`endif
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   if (DATA_W < 8 || DATA_W % 8 != 0 || DATA_W > PAR_MAX_W) begin : g_bad_data_w
      $fatal(1, "mem_param_ctrl: DATA_W=%0d must be a positive multiple of 8", DATA_W);
   end
   if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $fatal(1, "mem_param_ctrl: DEPTH=%0d must be in 1..2**ADDR_W", DEPTH);
   end
   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $fatal(1, "mem_param_ctrl: RD_LAT=%0d must be 1 or 2", RD_LAT);
   end

   localparam logic [1:0] IDLE    = ST_IDLE;
   localparam logic [1:0] RD_WAIT = ST_RD_WAIT;
   localparam logic [1:0] RSP     = ST_RSP;

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic              accept;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              oob_q;
   logic [DATA_W-1:0] rd_data;
   logic              rd_par_err;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   // Next-state: writes and single-cycle reads go straight to RSP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = (req_write || RD_LAT == RD_LAT_MIN) ? RSP : RD_WAIT;
         end
         RD_WAIT: state_d = RSP;
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset discards any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Capture the accepted request so the response stays stable in RSP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         oob_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= req_addr;
         write_q <= req_write;
         oob_q   <= int'(req_addr) >= DEPTH;
      end
   end

   mem_param_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk         (clk),
      .wr_en       (accept && req_write),
      .wr_addr     (req_addr),
      .wr_data     (req_wdata),
      .wr_be       (req_be),
`ifdef MEM_PARAM_PARITY_EN
      .wr_par_flip (par_inject),
`endif
      .rd_addr     (addr_q),
      .rd_data     (rd_data),
      .rd_par_err  (rd_par_err)
   );

   // Outputs derive from the state register only, so reset clears them at once.
   // The array cannot change while in RSP, so the read data is stable.
   assign rsp_valid = (state_q == RSP);
   assign rsp_rdata = (rsp_valid && !write_q) ? rd_data : '0;
   assign rsp_err   = rsp_valid && (oob_q || (!write_q && rd_par_err));

endmodule

// File: tb/tb_mem_param_ctrl.sv
`timescale 1ns/1ps
module tb_mem_param_ctrl;

   localparam int A_DEPTH = 20;
   localparam int B_DEPTH = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        req_valid [2];
   logic        req_write [2];
   logic [4:0]  req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_ready [2];
`ifdef MEM_PARAM_PARITY_EN
   logic        par_inject [2];
`endif

   logic        ready_a, valid_a, err_a;
   logic [7:0]  rdata_a;
   logic        ready_b, valid_b, err_b;
   logic [31:0] rdata_b;

   mem_param_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(A_DEPTH), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst[0]),
      .req_valid(req_valid[0]), .req_ready(ready_a), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0][7:0]), .req_be(req_be[0][0:0]),
`ifdef MEM_PARAM_PARITY_EN
      .par_inject(par_inject[0]),
`endif
      .rsp_valid(valid_a), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata_a), .rsp_err(err_a));

   mem_param_ctrl #(.ADDR_W(5), .DATA_W(32), .DEPTH(B_DEPTH), .RD_LAT(2)) dut_b (
      .clk(clk), .rst(rst[1]),
      .req_valid(req_valid[1]), .req_ready(ready_b), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
`ifdef MEM_PARAM_PARITY_EN
      .par_inject(par_inject[1]),
`endif
      .rsp_valid(valid_b), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata_b), .rsp_err(err_b));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: plain word arrays plus a "bad parity" flag per word.
   logic [31:0] mdl_mem [2][32];
   logic        mdl_bad [2][32];

   function automatic int depth_of(int d); return d == 0 ? A_DEPTH : B_DEPTH; endfunction
   function automatic int lat_of(int d);   return d == 0 ? 1 : 2;             endfunction
   function automatic logic [3:0] be_mask(int d); return d == 0 ? 4'h1 : 4'hF; endfunction

   function automatic logic        o_ready(int d); return d == 0 ? ready_a : ready_b; endfunction
   function automatic logic        o_valid(int d); return d == 0 ? valid_a : valid_b; endfunction
   function automatic logic        o_err(int d);   return d == 0 ? err_a   : err_b;   endfunction
   function automatic logic [31:0] o_rdata(int d); return d == 0 ? {24'h0, rdata_a} : rdata_b; endfunction

   function automatic void mdl_write(int d, int a, logic [31:0] w, logic [3:0] be, logic inj);
      if (a < depth_of(d)) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mdl_mem[d][a][8*i +: 8] = w[8*i +: 8];
         mdl_bad[d][a] = inj;
      end
   endfunction

   function automatic logic [31:0] exp_rdata(int d, logic wr, int a);
      if (wr || a >= depth_of(d)) return '0;
      return mdl_mem[d][a];
   endfunction

   function automatic logic exp_err(int d, logic wr, int a);
      if (a >= depth_of(d)) return 1'b1;
      return !wr && mdl_bad[d][a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one transaction and return what the DUT answered; handshake
   // rules (ready while busy, response stability) are checked on the way.
   task automatic do_txn(input int d, input logic wr, input logic [4:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic inj,
                         input int hold, output logic [31:0] rd, output logic er,
                         output int lat);
      logic [3:0]  be_m;
      logic        inj_eff;
      logic [31:0] first_rd;
      logic        first_er;
      be_m = be & be_mask(d);
`ifdef MEM_PARAM_PARITY_EN
      inj_eff = inj;
      par_inject[d] = inj;
`else
      inj_eff = 1'b0 & inj;
`endif
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      req_be[d]    = be_m;
      chk("ready_in_idle", {31'h0, o_ready(d)}, 32'h1);
      step();
      req_valid[d] = 1'b0;
      if (wr) mdl_write(d, int'(addr), wd, be_m, inj_eff);
      lat = 1;
      while (!o_valid(d) && lat < 6) begin
         chk("ready_while_busy", {31'h0, o_ready(d)}, 32'h0);
         step();
         lat++;
      end
      first_rd = o_rdata(d);
      first_er = o_err(d);
      for (int k = 0; k < hold; k++) begin
         rsp_ready[d] = 1'b0;
         step();
         chk("hold_valid", {31'h0, o_valid(d)}, 32'h1);
         chk("hold_rdata", o_rdata(d), first_rd);
         chk("hold_err", {31'h0, o_err(d)}, {31'h0, first_er});
         chk("hold_ready", {31'h0, o_ready(d)}, 32'h0);
      end
      rsp_ready[d] = 1'b1;
      step();
      rsp_ready[d] = 1'b0;
      chk("done_valid", {31'h0, o_valid(d)}, 32'h0);
      chk("done_ready", {31'h0, o_ready(d)}, 32'h1);
      rd = first_rd;
      er = first_er;
   endtask

   task automatic run_model(input int d, input logic wr, input logic [4:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input logic inj,
                            input int hold, output logic [31:0] rd, output logic er);
      logic [31:0] e_rd;
      logic        e_er;
      int          lat;
      e_rd = exp_rdata(d, wr, int'(addr));
      e_er = exp_err(d, wr, int'(addr));
      do_txn(d, wr, addr, wd, be, inj, hold, rd, er, lat);
      chk("mdl_rdata", rd, e_rd);
      chk("mdl_err", {31'h0, er}, {31'h0, e_er});
      chk("mdl_latency", 32'(lat), wr ? 32'd1 : 32'(lat_of(d)));
   endtask

   typedef struct {
      int          d;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [3:0]  be;
      int          hold;
      logic [31:0] exp_rd;
      logic        exp_er;
      int          exp_lat;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2000000;
      $display("FAIL watchdog: run still active, required finish before 2 ms");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
         req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
`ifdef MEM_PARAM_PARITY_EN
         par_inject[d] = 1'b0;
`endif
         for (int a = 0; a < 32; a++) begin
            mdl_mem[d][a] = '0;
            mdl_bad[d][a] = 1'b0;
         end
      end

      #2;
      for (int d = 0; d < 2; d++) begin
         chk("reset_req_ready", {31'h0, o_ready(d)}, 32'h1);
         chk("reset_rsp_valid", {31'h0, o_valid(d)}, 32'h0);
         chk("reset_rsp_rdata", o_rdata(d), 32'h0);
         chk("reset_rsp_err", {31'h0, o_err(d)}, 32'h0);
      end
      step(); step();
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      step();

      // Known contents everywhere so later reads have defined expectations.
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < depth_of(d); a++)
            run_model(d, 1'b1, 5'(a), $urandom, 4'hF, 1'b0, 0, rd, er);

      tbl.push_back('{0, 1'b1, 5'd5,  32'h41,       4'h1, 0, 32'h0,        1'b0, 1});
      tbl.push_back('{0, 1'b0, 5'd5,  32'h0,        4'h0, 1, 32'h41,       1'b0, 1});
      tbl.push_back('{0, 1'b1, 5'd19, 32'hC3,       4'h1, 0, 32'h0,        1'b0, 1});
      tbl.push_back('{0, 1'b0, 5'd19, 32'h0,        4'h0, 0, 32'hC3,       1'b0, 1});
      tbl.push_back('{0, 1'b1, 5'd25, 32'hFF,       4'h1, 0, 32'h0,        1'b1, 1});
      tbl.push_back('{0, 1'b0, 5'd25, 32'h0,        4'h0, 0, 32'h0,        1'b1, 1});
      tbl.push_back('{0, 1'b1, 5'd20, 32'h99,       4'h1, 0, 32'h0,        1'b1, 1});
      tbl.push_back('{0, 1'b0, 5'd20, 32'h0,        4'h0, 2, 32'h0,        1'b1, 1});
      tbl.push_back('{1, 1'b1, 5'd3,  32'hAABBCCDD, 4'hF, 0, 32'h0,        1'b0, 1});
      tbl.push_back('{1, 1'b1, 5'd3,  32'h11223344, 4'h5, 0, 32'h0,        1'b0, 1});
      tbl.push_back('{1, 1'b0, 5'd3,  32'h0,        4'h0, 3, 32'hAA22CC44, 1'b0, 2});
      tbl.push_back('{1, 1'b1, 5'd31, 32'hDEADBEEF, 4'hF, 1, 32'h0,        1'b0, 1});
      tbl.push_back('{1, 1'b0, 5'd31, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 2});

      foreach (tbl[i]) begin
         do_txn(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, 1'b0,
                tbl[i].hold, rd, er, lat);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_er});
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      end

      // Out-of-range writes above must not have touched words 0..19.
      for (int a = 0; a < A_DEPTH; a++)
         run_model(0, 1'b0, 5'(a), 32'h0, 4'h0, 1'b0, 0, rd, er);

      // rsp_ready with no response pending does nothing.
      rsp_ready[0] = 1'b1;
      step(); step();
      chk("idle_rsp_ready_valid", {31'h0, valid_a}, 32'h0);
      chk("idle_rsp_ready_ready", {31'h0, ready_a}, 32'h1);
      rsp_ready[0] = 1'b0;

      // Backpressure: read 5 held for 4 cycles while a write to 6 waits.
      begin
         logic [7:0] held;
         req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 5'd5; req_be[0] = 4'h0;
         step();
         req_write[0] = 1'b1; req_addr[0] = 5'd6; req_wdata[0] = 32'h77; req_be[0] = 4'h1;
         held = rdata_a;
         chk("bp_first_valid", {31'h0, valid_a}, 32'h1);
         chk("bp_rdata", {24'h0, held}, mdl_mem[0][5]);
         for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_valid", {31'h0, valid_a}, 32'h1);
            chk("bp_stable", {24'h0, rdata_a}, {24'h0, held});
            chk("bp_ready", {31'h0, ready_a}, 32'h0);
         end
         rsp_ready[0] = 1'b1;
         step();
         rsp_ready[0] = 1'b0;
         chk("bp_back_idle_valid", {31'h0, valid_a}, 32'h0);
         chk("bp_back_idle_ready", {31'h0, ready_a}, 32'h1);
         step();
         req_valid[0] = 1'b0;
         mdl_write(0, 6, 32'h77, 4'h1, 1'b0);
         chk("bp_second_rsp_valid", {31'h0, valid_a}, 32'h1);
         chk("bp_second_rsp_err", {31'h0, err_a}, 32'h0);
         rsp_ready[0] = 1'b1;
         step();
         rsp_ready[0] = 1'b0;
         run_model(0, 1'b0, 5'd6, 32'h0, 4'h0, 1'b0, 0, rd, er);
         chk("bp_second_write_data", rd, 32'h77);
      end

      // Reset while a response is presented: outputs clear without a clock edge.
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 5'd25;
      step();
      req_valid[0] = 1'b0;
      chk("rsp_before_rst_err", {31'h0, err_a}, 32'h1);
      #2 rst[0] = 1'b1;
      #1;
      chk("async_rst_valid_a", {31'h0, valid_a}, 32'h0);
      chk("async_rst_err_a", {31'h0, err_a}, 32'h0);
      chk("async_rst_ready_a", {31'h0, ready_a}, 32'h1);
      step();
      rst[0] = 1'b0;
      step();
      chk("post_rst_valid_a", {31'h0, valid_a}, 32'h0);

      // Reset during RD_WAIT on the two-cycle instance; memory survives.
      run_model(1, 1'b1, 5'd7, 32'h5A, 4'h1, 1'b0, 0, rd, er);
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 5'd7;
      step();
      req_valid[1] = 1'b0;
      chk("rdwait_valid", {31'h0, valid_b}, 32'h0);
      chk("rdwait_ready", {31'h0, ready_b}, 32'h0);
      #2 rst[1] = 1'b1;
      #1;
      chk("async_rst_valid_b", {31'h0, valid_b}, 32'h0);
      chk("async_rst_ready_b", {31'h0, ready_b}, 32'h1);
      chk("async_rst_rdata_b", rdata_b, 32'h0);
      step(); step();
      rst[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("no_stale_rsp_b", {31'h0, valid_b}, 32'h0);
      end
      run_model(1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 0, rd, er);
      chk("retained_after_rst", {24'h0, rd[7:0]}, 32'h5A);

`ifdef MEM_PARAM_PARITY_EN
      run_model(0, 1'b1, 5'd2, 32'h0F, 4'h1, 1'b1, 0, rd, er);
      run_model(0, 1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 0, rd, er);
      chk("parity_rdata", rd, 32'h0F);
      chk("parity_err", {31'h0, er}, 32'h1);
      run_model(0, 1'b1, 5'd2, 32'h0F, 4'h1, 1'b0, 0, rd, er);
      run_model(0, 1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 0, rd, er);
      chk("parity_clean_err", {31'h0, er}, 32'h0);
`endif

      for (int n = 0; n < 120; n++) begin
         int d;
         d = int'($urandom_range(0, 1));
         run_model(d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   4'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), rd, er);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_param_ctrl.md
MEM_PARAM_CTRL -- requirements
Module: mem_param_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, word width in bits, a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 32, number of words, 1..2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles, 1 or 2.
REQ-005 SHALL have the following ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables; writes only.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  error flag for the response.

Function
REQ-006 SHALL use FSM states IDLE, RD_WAIT and RSP.
REQ-007 req_ready SHALL be 1 only in IDLE.
REQ-008 Request SHALL be accepted on an edge where req_valid && req_ready.
REQ-009 Write path:
- On acceptance, bytes with req_be[i]=1 are written at that same edge.
- Bytes with req_be[i]=0 keep their old value.
- FSM goes to RSP.
REQ-010 Read path:
- RD_LAT=1: accept -> RSP.
- RD_LAT=2: accept -> RD_WAIT for exactly one cycle -> RSP.
- rsp_valid SHALL first be high RD_LAT cycles after the acceptance edge.
REQ-011 In RSP:
- rsp_valid=1.
- rsp_rdata, rsp_err stable until the edge with rsp_ready=1.
- That edge returns the FSM to IDLE.
- Minimum spacing between accepts is 2 cycles (write) or RD_LAT+1 cycles (read).
REQ-012 Address req_addr >= DEPTH is out of range:
- Write: memory is not modified.
- Read: rsp_rdata=0.
- Both: rsp_err=1.
REQ-013 In-range transactions SHALL return rsp_err=0 unless REQ-019 applies.
REQ-014 A read of an address written by the immediately preceding transaction SHALL return the new data.
REQ-015 Requests presented while req_ready=0 SHALL be ignored and SHALL NOT be captured.
REQ-016 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-017 While rst=1, regardless of clk:
- FSM = IDLE, req_ready=1.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Any pending transaction or response is discarded with no response.
REQ-018 Memory array contents SHALL NOT be reset.
- Data written before a mid-operation reset is retained.
- A write accepted at an edge before reset assertion persists.

Configuration
REQ-019 Macro MEM_PARAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per word and recomputed on every write.
  - Input port par_inject (1 bit): when 1 on a write accept, the stored parity bit is inverted.
  - A read of a word with parity mismatch returns the stored data with rsp_err=1.
- Undefined: no parity storage, no par_inject port, and rsp_err only per REQ-012.

Structure
REQ-020 Package mem_param_pkg SHALL hold:
- the FSM state enum;
- RD_LAT_MIN=1 and RD_LAT_MAX=2 constants;
- the parity function.
REQ-021 Storage, byte-enable write and optional parity SHALL be in sub-module mem_param_array.
REQ-022 FSM and handshake SHALL be in mem_param_ctrl.
REQ-023 Parameter legality (DEPTH, RD_LAT, DATA_W%8) SHALL be checked at elaboration with a fatal error.

Verification
REQ-024 Write, then read with rsp_ready=1 and defaults:
- Stimulus: write addr 5, data 8'h41, be 1; then read addr 5.
- Response: write response rsp_err=0, rsp_rdata=0; read rsp_rdata=8'h41, rsp_err=0, rsp_valid exactly 1 cycle after read accept.
REQ-025 Byte enables and RD_LAT=2:
- Setup: DATA_W=32, RD_LAT=2.
- Stimulus: write addr 3, 32'hAABBCCDD, be 4'hF; write addr 3, 32'h11223344, be 4'b0101; read addr 3.
- Response: read returns 32'hAA22CC44, rsp_valid first high 2 cycles after accept.
REQ-026 Out-of-range access:
- Setup: DEPTH=20.
- Stimulus: write addr 25, data 8'hFF; read addr 25.
- Response: both responses rsp_err=1, read rsp_rdata=0; words 0..19 unchanged.
REQ-027 Response backpressure:
- Stimulus: read with rsp_ready=0 for 4 cycles, then 1; req_valid held high with a new request throughout.
- Response: rsp_valid, rsp_rdata stable for 5 cycles, req_ready=0 throughout; second request accepted only after return to IDLE.
REQ-028 Reset mid-transaction:
- Setup: RD_LAT=2.
- Stimulus: write addr 7, 8'h5A; accept a read; assert rst during RD_WAIT.
- Response: rsp_valid=0, req_ready=1 immediately and asynchronously; after rst deasserts, read addr 7 returns 8'h5A.
REQ-029 With MEM_PARAM_PARITY_EN defined:
- Stimulus: write addr 2, 8'h0F with par_inject=1; read addr 2.
- Response: rsp_rdata=8'h0F, rsp_err=1.
